// File: rtl/mult_block_host.sv
// rtl/mult_block_host.sv - host controller feeding one operand block to the multiplier and summing its read-back
// Optional max-product tracking (max_val/max_idx) is enabled by defining MULT_BLOCK_HOST_MAX_EN.
module mult_block_host #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [15:0]               op_a,
    input  logic [15:0]               op_b,
    output logic                      EN_mult,
    output logic [15:0]               mult_input0,
    output logic [15:0]               mult_input1,
    input  logic                      RDY_mult,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      busy,
    output logic [WIDTH+LOGDEPTH-1:0] result,
    output logic                      result_valid,
    output logic                      err_timeout,
    output logic                      err_unexpected
`ifdef MULT_BLOCK_HOST_MAX_EN
    ,
    output logic [WIDTH-1:0]          max_val,
    output logic [LOGDEPTH-1:0]       max_idx
`endif
);

    localparam int AW = WIDTH + LOGDEPTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LOGDEPTH-1:0] LAST     = {LOGDEPTH{1'b1}};
    localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_REQ, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [LOGDEPTH-1:0] feed_cnt_q, feed_cnt_d;
    logic [LOGDEPTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [AW-1:0]       result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_unexpected_q, err_unexpected_d;
    logic [AW-1:0]       word_ext;

    assign word_ext = AW'(memVal_data);

    always_comb begin
        state_d          = state_q;
        feed_cnt_d       = feed_cnt_q;
        rd_cnt_d         = rd_cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        acc_d            = acc_q;
        result_d         = result_q;
        result_valid_d   = 1'b0;
        err_timeout_d    = err_timeout_q;
        err_unexpected_d = err_unexpected_q;
        op_ready         = 1'b0;
        EN_mult          = 1'b0;
        mult_input0      = '0;
        mult_input1      = '0;
        EN_blockRead     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (VALID_memVal) begin
                    err_unexpected_d = 1'b1;
                end
                if (start) begin
                    state_d          = S_FEED;
                    feed_cnt_d       = '0;
                    rd_cnt_d         = '0;
                    acc_d            = '0;
                    err_timeout_d    = 1'b0;
                    err_unexpected_d = 1'b0;
                end
            end
            S_FEED: begin
                op_ready    = RDY_mult;
                EN_mult     = op_valid;
                mult_input0 = op_a;
                mult_input1 = op_b;
                if (VALID_memVal) begin
                    err_unexpected_d = 1'b1;
                end
                if (op_valid && RDY_mult) begin
                    feed_cnt_d = feed_cnt_q + 1'b1;
                    if (feed_cnt_q == LAST) begin
                        state_d   = S_REQ;
                        tmo_cnt_d = '0;
                    end
                end
            end
            S_REQ: begin
                // Request stays asserted until the first word arrives or we give up.
                EN_blockRead = 1'b1;
                if (VALID_memVal) begin
                    acc_d    = word_ext;
                    rd_cnt_d = LOGDEPTH'(1);
                    state_d  = S_DRAIN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (VALID_memVal) begin
                    if (rd_cnt_q == LAST) begin
                        result_d       = acc_q + word_ext;
                        result_valid_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        acc_d    = acc_q + word_ext;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            feed_cnt_q       <= '0;
            rd_cnt_q         <= '0;
            tmo_cnt_q        <= '0;
            acc_q            <= '0;
            result_q         <= '0;
            result_valid_q   <= 1'b0;
            err_timeout_q    <= 1'b0;
            err_unexpected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            feed_cnt_q       <= feed_cnt_d;
            rd_cnt_q         <= rd_cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            acc_q            <= acc_d;
            result_q         <= result_d;
            result_valid_q   <= result_valid_d;
            err_timeout_q    <= err_timeout_d;
            err_unexpected_q <= err_unexpected_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign err_timeout    = err_timeout_q;
    assign err_unexpected = err_unexpected_q;

`ifdef MULT_BLOCK_HOST_MAX_EN
    logic [WIDTH-1:0]    run_max_q, run_max_d, max_val_q, max_val_d;
    logic [LOGDEPTH-1:0] run_idx_q, run_idx_d, max_idx_q, max_idx_d;
    logic                word_gt;

    // Strict compare so ties keep the earlier read index.
    assign word_gt = memVal_data > run_max_q;

    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (VALID_memVal) begin
            if (state_q == S_REQ) begin
                run_max_d = memVal_data;
                run_idx_d = '0;
            end else if (state_q == S_DRAIN) begin
                if (word_gt) begin
                    run_max_d = memVal_data;
                    run_idx_d = rd_cnt_q;
                end
                if (rd_cnt_q == LAST) begin
                    max_val_d = word_gt ? memVal_data : run_max_q;
                    max_idx_d = word_gt ? rd_cnt_q : run_idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_val = max_val_q;
    assign max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_mult_block_host.sv
// tb/tb_mult_block_host.sv - scoreboard bench for mult_block_host with multiplier/memory model
module tb_mult_block_host;
    localparam int LOGDEPTH = 6;
    localparam int WIDTH    = 32;
    localparam int TIMEOUT  = 255;
    localparam int DEPTH    = 64;
    localparam int AW       = WIDTH + LOGDEPTH;

    logic              clk = 1'b0;
    logic              rst, start, op_valid, RDY_mult, VALID_memVal;
    logic [15:0]       op_a, op_b;
    logic [WIDTH-1:0]  memVal_data;
    logic              op_ready, EN_mult, EN_blockRead, busy, result_valid;
    logic              err_timeout, err_unexpected;
    logic [15:0]       mult_input0, mult_input1;
    logic [AW-1:0]     result;
`ifdef MULT_BLOCK_HOST_MAX_EN
    logic [WIDTH-1:0]    max_val;
    logic [LOGDEPTH-1:0] max_idx;
`endif

    mult_block_host #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .EN_mult(EN_mult), .mult_input0(mult_input0),
        .mult_input1(mult_input1), .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data), .busy(busy),
        .result(result), .result_valid(result_valid), .err_timeout(err_timeout),
        .err_unexpected(err_unexpected)
`ifdef MULT_BLOCK_HOST_MAX_EN
        , .max_val(max_val), .max_idx(max_idx)
`endif
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [31:0]      exp_pairs[$];
    logic [WIDTH-1:0] prod_q[$];
    logic [AW-1:0]    exp_res[$];
    logic [AW-1:0]    last_res = '0;
    logic [31:0]      mon_pr;
    logic [AW-1:0]    mon_res;
`ifdef MULT_BLOCK_HOST_MAX_EN
    logic [WIDTH-1:0] exp_max[$];
    int               exp_idx[$];
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outs"}, {op_ready, EN_mult, EN_blockRead, busy, result_valid,
                               err_timeout, err_unexpected}, 0);
        check({tag, "_mult_inputs"}, {mult_input0, mult_input1}, 0);
        check({tag, "_result"}, result, 0);
`ifdef MULT_BLOCK_HOST_MAX_EN
        check({tag, "_max"}, {max_val, max_idx}, 0);
`endif
    endtask

    // Monitor: multiplier model, idle gating, and result scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (EN_mult && RDY_mult) begin
                if (exp_pairs.size() == 0) begin
                    check("spurious_transfer", 1, 0);
                end else begin
                    mon_pr = exp_pairs.pop_front();
                    check("operands", {mult_input0, mult_input1}, mon_pr);
                    prod_q.push_back(32'(mon_pr[31:16]) * 32'(mon_pr[15:0]));
                end
            end
            if (!busy) begin
                check("idle_gating", {EN_mult, op_ready, EN_blockRead, mult_input0, mult_input1}, 0);
            end
            if (result_valid) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_result_valid", 1, 0);
                end else begin
                    mon_res = exp_res.pop_front();
                    check("result", result, mon_res);
                    last_res = mon_res;
`ifdef MULT_BLOCK_HOST_MAX_EN
                    check("max_val", max_val, exp_max.pop_front());
                    check("max_idx", max_idx, exp_idx.pop_front());
`endif
                end
            end
        end
    end

    // pat: 0 ramp*2, 1 all 0xFFFF, 2 random, 3 products 5,9,9,3,...
    // bp: 0 none, 1 RDY toggles / op_valid drops every 3rd, 2 random
    // gap: 0 back-to-back, 1 every other cycle, 2 random, 3 never (timeout)
    task automatic run_block(input int pat, input int bp, input int gap, input int bad, input int rst_at);
        logic [15:0]      a[DEPTH];
        logic [15:0]      b[DEPTH];
        longint unsigned  s;
        logic [WIDTH-1:0] p, mx;
        int               mi, i, cyc, k, guard, lat, n;
        logic             v, tog;
        s = 0; mx = 0; mi = 0;
        for (int j = 0; j < DEPTH; j++) begin
            case (pat)
                0: begin a[j] = 16'(j + 1); b[j] = 16'd2; end
                1: begin a[j] = 16'hFFFF; b[j] = 16'hFFFF; end
                2: begin a[j] = 16'($urandom); b[j] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom); end
                default: begin
                    a[j] = (j == 0) ? 16'd5 : (j < 3) ? 16'd9 : (j == 3) ? 16'd3 : 16'($urandom_range(0, 8));
                    b[j] = 16'd1;
                end
            endcase
            p = 32'(a[j]) * 32'(b[j]);
            s += longint'(p);
            if (j == 0 || p > mx) begin mx = p; mi = j; end
            exp_pairs.push_back({a[j], b[j]});
        end
        if (gap != 3 && rst_at < 0) begin
            exp_res.push_back(AW'(s));
`ifdef MULT_BLOCK_HOST_MAX_EN
            exp_max.push_back(mx);
            exp_idx.push_back(mi);
`endif
        end

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        i = 0; cyc = 0;
        while (i < DEPTH && cyc < 2000) begin
            case (bp)
                0: begin RDY_mult = 1'b1; op_valid = 1'b1; end
                1: begin RDY_mult = (cyc % 2 == 0); op_valid = (cyc % 3 != 2); end
                default: begin RDY_mult = ($urandom_range(0, 3) != 0); op_valid = ($urandom_range(0, 3) != 0); end
            endcase
            op_a = a[i]; op_b = b[i];
            VALID_memVal = (bad != 0) && (cyc == 5);
            memVal_data = $urandom;
            @(negedge clk);
            if (cyc == 0) begin
                check("start_busy", busy, 1);
                check("start_clears_errs", {err_timeout, err_unexpected}, 0);
                check("result_holds", result, last_res);
            end
            check("op_ready_mirror", op_ready, RDY_mult);
            if (op_valid && op_ready) i++;
            cyc++;
            @(posedge clk); #1;
        end
        if (i < DEPTH) check("feed_budget", 0, 1);
        VALID_memVal = 1'b0; op_valid = 1'b0; RDY_mult = 1'b1;
        @(negedge clk);
        check("blockread_on", EN_blockRead, 1);
        check("transfers", prod_q.size(), DEPTH);
        check("err_unexpected", err_unexpected, (bad != 0));

        if (gap == 3) begin
            n = 1;
            for (int c = 0; c < 400 && EN_blockRead; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (EN_blockRead) n++;
            end
            check("timeout_cycles", n, TIMEOUT);
            check("timeout_flag_idle", {err_timeout, busy}, 2'b10);
            prod_q.delete();
            return;
        end

        lat = $urandom_range(0, 20);
        k = 0; guard = 0; tog = 1'b0;
        while (k < DEPTH && guard < 1000) begin
            @(posedge clk); #1;
            if (k == rst_at) begin
                rst = 1'b1; VALID_memVal = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_reset_outputs("mid_reset");
                prod_q.delete();
                last_res = '0;
                return;
            end
            tog = ~tog;
            if (lat > 0) begin v = 1'b0; lat--; end
            else if (gap == 0) v = 1'b1;
            else if (gap == 1) v = tog;
            else v = 1'($urandom_range(0, 1));
            VALID_memVal = v;
            memVal_data = v ? prod_q[k] : $urandom;
            @(negedge clk);
            if (v) k++;
            guard++;
        end
        if (k < DEPTH) check("read_budget", 0, 1);
        @(posedge clk); #1;
        VALID_memVal = 1'b0;
        @(negedge clk);
        check("result_latency", result_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("result_pulse_idle", {result_valid, busy}, 0);
        prod_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op_valid = 1'b0; RDY_mult = 1'b0;
        VALID_memVal = 1'b0; op_a = 16'h1234; op_b = 16'h5678; memVal_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_block(0, 0, 0, 0, -1);
        run_block(0, 1, 0, 0, -1);
        run_block(1, 0, 0, 0, -1);
        run_block(2, 2, 1, 0, -1);
        run_block(2, 2, 3, 0, -1);
        run_block(2, 0, 0, 1, -1);
        run_block(2, 2, 2, 0, 20);
        run_block(2, 2, 2, 0, -1);
        run_block(3, 1, 0, 0, -1);
        for (int r = 0; r < 3; r++) begin
            run_block(2, 2, 2, 0, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("pending_results", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_block_host.md
# mult_block_host

Host-side controller for the block multiplier: the other end of its operand and block-read interfaces. Accepts operand pairs from an upstream valid/ready source and forwards exactly one block of DEPTH pairs while honouring RDY_mult. It then requests the block read-back, collects the DEPTH products streamed on VALID_memVal/memVal_data, and reports their sum, a dot product of the block, as a single result.

## Interface
- LOGDEPTH, 6: log2 of block depth; DEPTH = 2**LOGDEPTH pairs per block.
- WIDTH, 32: product/read-data width.
- TIMEOUT, 255: max cycles in REQ without a VALID_memVal before abort.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins one block transaction from IDLE.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  upstream pair consumed this cycle when op_valid && op_ready.
- op_a, op_b  in  16 each  upstream operands.
- EN_mult  out  1  operand pair presented to multiplier.
- mult_input0, mult_input1  out  16 each  operands to multiplier.
- RDY_mult  in  1  multiplier can accept a pair.
- EN_blockRead  out  1  request block read-back.
- VALID_memVal  in  1  memVal_data carries a product.
- memVal_data  in  WIDTH  product read back.
- busy  out  1  high in any state other than IDLE.
- result  out  WIDTH+LOGDEPTH  sum of the DEPTH products; holds until the next result.
- result_valid  out  1  one-cycle pulse when result updates.
- err_timeout  out  1  sticky; REQ timed out; cleared by accepted start.
- err_unexpected  out  1  sticky; VALID_memVal high outside REQ/DRAIN; cleared by accepted start.

## Operation
- States: IDLE, FEED, REQ, DRAIN.
- IDLE: EN_mult=0, EN_blockRead=0, op_ready=0. start=1 -> FEED. Also clears feed_cnt, rd_cnt, acc, err_*. start outside IDLE is ignored.
- FEED:
  - EN_mult = op_valid; mult_input0/1 = op_a/op_b (combinational pass-through).
  - op_ready = RDY_mult.
  - A pair transfers when op_valid && RDY_mult; feed_cnt increments.
  - Transfer with feed_cnt==DEPTH-1 -> REQ.
  - No transfer: state and count hold.
- REQ:
  - EN_blockRead=1 and held every cycle, even if the multiplier ignores it until full.
  - First VALID_memVal=1: word accumulated, rd_cnt=1, -> DRAIN.
  - TIMEOUT consecutive cycles without VALID: err_timeout=1 -> IDLE, no result_valid.
- DRAIN:
  - EN_blockRead=0.
  - Each cycle with VALID_memVal=1: acc += zero-extended memVal_data; rd_cnt increments. Gaps (VALID=0) are allowed and wait.
  - Word with rd_cnt==DEPTH-1: result <= acc + word, result_valid pulse -> IDLE.
- Arithmetic: acc is WIDTH+LOGDEPTH bits, unsigned; overflow is impossible for DEPTH words.
- VALID_memVal=1 in IDLE or FEED: data ignored, err_unexpected=1.
- Reset mid-operation: immediate return to IDLE, counters and accumulator cleared, no result_valid. result and err_* take reset values.

## Timing
- Reset values: op_ready=0, EN_mult=0, mult_input0/1=0 (mult_input0/1 follow op_a/op_b only in FEED, else 0), EN_blockRead=0, busy=0, result=0, result_valid=0, err_timeout=0, err_unexpected=0.
- start at edge t -> FEED from cycle t+1; first pair can transfer in cycle t+1.
- Throughput: one pair per cycle while op_valid && RDY_mult.
- Last pair at cycle t -> EN_blockRead=1 from cycle t+1.
- Last VALID word at cycle t -> result_valid=1 and result updated in cycle t+1.
- Timeout counter restarts on each REQ entry; abort occurs on the TIMEOUT-th empty REQ cycle.

## Configuration
- MULT_BLOCK_HOST_MAX_EN
  - Defined: adds outputs max_val (WIDTH) and max_idx (LOGDEPTH), updated with result_valid. They give the largest product in the block and the read index of its first occurrence; ties keep the lower index. Reset value 0.
  - Undefined: neither port nor tracking logic exists.

## Test plan
- Basic: DEPTH=64, op_a=i+1, op_b=2 for i=0..63, RDY_mult=1; model returns the products in 64 back-to-back VALID cycles -> result=4160, single result_valid pulse, 64 EN_mult transfers.
- Backpressure: RDY_mult toggles 1,0 and op_valid drops every 3rd cycle -> op_ready mirrors RDY_mult in FEED, exactly 64 transfers, operands in order, result unchanged (4160).
- Max products: all pairs 0xFFFF x 0xFFFF -> result = 64*0xFFFE0001 = 0x3FFF800040, no overflow.
- Read gaps and timeout:
  - VALID_memVal inserted every other cycle -> correct sum, result_valid one cycle after the 64th word.
  - Separate run with no VALID for 255 cycles in REQ -> err_timeout=1, IDLE, no result_valid.
- Error and reset:
  - VALID_memVal pulse in FEED -> err_unexpected=1, sum excludes that word.
  - rst asserted mid-DRAIN -> all outputs at reset values next cycle; a new start completes normally.
- With MULT_BLOCK_HOST_MAX_EN: products 5,9,9,3,... -> max_val=9, max_idx=1.
